dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 INDEXWIDTH, 6, line index bits; the cache has 2**INDEXWIDTH one-word lines.
REQ-002 TAGWIDTH, 30-INDEXWIDTH, tag bits taken from core_addr[31:INDEXWIDTH+2].
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 core_req  in  1  core access request, held stable while core_stall=1.
REQ-006 core_we  in  1  1=write, 0=read.
REQ-007 core_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 core_wdata  in  32  write data.
REQ-009 core_rdata  out  32  read data, valid only in the done cycle.
REQ-010 core_stall  out  1  core_req && !done.
REQ-011 arr_index  out  INDEXWIDTH  shared index to valid/tag/data arrays.
REQ-012 arr_cs / arr_oe / arr_web  out  1 each  array chip-select, output-enable, active-low write-enable.
REQ-013 valid_q  in  1 / valid_din  out  1  valid array read/write data.
REQ-014 tag_q  in  TAGWIDTH / tag_din  out  TAGWIDTH  tag array read/write data.
REQ-015 data_q  in  32 / data_din  out  32  data array read/write data.
REQ-016 mem_req, mem_we  out  1; mem_addr, mem_wdata  out  32; mem_rdata  in  32; mem_ack  in  1  next-level memory port.

Function
REQ-017 States: IDLE, LOOKUP, READ_MISS, WRITE_MEM (plus FLUSH, see REQ-030).
REQ-018 IDLE, core_req=1: latch addr/we/wdata; arr_cs=1, arr_oe=1, arr_web=1, arr_index=addr[INDEXWIDTH+1:2]; go LOOKUP.
REQ-019 LOOKUP: hit = valid_q && (tag_q == latched tag); arrays sampled only in this state.
REQ-020 Read hit: core_rdata=data_q, done=1 in LOOKUP, go IDLE. Total latency: 2 cycles, request cycle included.
REQ-021 Read miss: go READ_MISS; mem_req=1, mem_we=0, mem_addr=latched addr with [1:0]=0.
REQ-022 READ_MISS on mem_ack: write arrays (arr_cs=1, arr_web=0, valid_din=1, tag_din=tag, data_din=mem_rdata); core_rdata=mem_rdata; done=1; go IDLE.
REQ-023 Write (hit or miss): record hit; go WRITE_MEM; mem_req=1, mem_we=1, mem_wdata=latched wdata. Policy: write-through, no-write-allocate.
REQ-024 WRITE_MEM on mem_ack: done=1. On a recorded hit, also write data_din=wdata, tag_din=tag, valid_din=1. On a miss, leave arrays untouched. Go IDLE.
REQ-025 Memory handshake:
- mem_req, mem_addr and mem_wdata held constant until the mem_ack cycle.
- mem_req deasserted the cycle after mem_ack.
- mem_ack outside READ_MISS/WRITE_MEM is ignored.
REQ-026 Outside the cases above: arr_cs=0, arr_web=1, core_rdata=0, mem_req=0.
REQ-027 A new request is accepted no earlier than the IDLE cycle after done; no back-to-back overlap.

Reset
REQ-028 On rst: state=IDLE, latched fields cleared. Outputs: mem_req=0, arr_cs=0, arr_web=1, core_rdata=0.
REQ-029 rst mid-transaction abandons the access: no array write; mem_req low the cycle after the reset edge.

Configuration
REQ-030 Macro CACHE_FLUSH_EN. When defined, the block adds:
- Ports flush_req in 1 and valid_flush out 1, plus state FLUSH.
- In IDLE, flush_req has priority over core_req: go FLUSH, assert valid_flush for exactly one cycle, return to IDLE.
- flush_req arriving in another state is serviced on the next IDLE.
REQ-031 Without CACHE_FLUSH_EN: no flush ports and no FLUSH state.

Structure
REQ-032 Package cache_pkg holds the state enum, the INDEXWIDTH/TAGWIDTH defaults and the address-field extraction functions.
REQ-033 No sub-module; the valid/tag/data arrays are instantiated outside this block.

Verification
REQ-034 Cold read of 0x0000_0040 (valid_q=0) -> mem_req with mem_addr=0x40. mem_ack with rdata=0xDEADBEEF after 3 cycles -> core_rdata=0xDEADBEEF and a valid/tag/data write at index 16, same cycle.
REQ-035 Repeat read of 0x40 -> done in LOOKUP, core_rdata=0xDEADBEEF, mem_req stays 0; 2-cycle latency.
REQ-036 Write 0x40 with data 0x12345678 on a hit -> mem_we=1; on mem_ack, data array written with 0x12345678. Write to 0x80 on a miss -> no array write.
REQ-037 Read of 0x1000_0040 (same index, different tag) -> miss, refill overwrites tag at index 16.
REQ-038 rst asserted in READ_MISS before mem_ack -> state IDLE, mem_req=0 next cycle, no array write.
REQ-039 CACHE_FLUSH_EN defined: flush_req and core_req together in IDLE -> valid_flush high one cycle, then the read is serviced as a miss.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache.
// Optional line flush is enabled with CACHE_FLUSH_EN.
package cache_pkg;

    localparam int INDEXWIDTH_DEF = 6;
    localparam int TAGWIDTH_DEF   = 30 - INDEXWIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        READ_MISS,
        WRITE_MEM
`ifdef CACHE_FLUSH_EN
        , FLUSH
`endif
    } state_t;

    function automatic logic [31:0] addr_index(
        input logic [31:0] a,
        input int          iw
    );
        return (a >> 2) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(
        input logic [31:0] a,
        input int          iw
    );
        return a >> (iw + 2);
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Next-level memory port of the data cache controller.
// master = cache side, slave = memory side.
interface dcache_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define CACHE_FLUSH_EN to add the flush_req/valid_flush handshake.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEXWIDTH = INDEXWIDTH_DEF,
    parameter int TAGWIDTH   = 30 - INDEXWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [31:0]           core_addr,
    input  logic [31:0]           core_wdata,
    output logic [31:0]           core_rdata,
    output logic                  core_stall,
    output logic [INDEXWIDTH-1:0] arr_index,
    output logic                  arr_cs,
    output logic                  arr_oe,
    output logic                  arr_web,
    input  logic                  valid_q,
    output logic                  valid_din,
    input  logic [TAGWIDTH-1:0]   tag_q,
    output logic [TAGWIDTH-1:0]   tag_din,
    input  logic [31:0]           data_q,
    output logic [31:0]           data_din,
`ifdef CACHE_FLUSH_EN
    input  logic                  flush_req,
    output logic                  valid_flush,
`endif
    dcache_ctrl_if.master         mem
);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        hit_q;
    logic        mem_req_q;

    logic [INDEXWIDTH-1:0] idx_core;
    logic [INDEXWIDTH-1:0] idx_lat;
    logic [TAGWIDTH-1:0]   tag_lat;
    logic hit;
    logic flush_go;
    logic accept;
    logic rd_hit;
    logic fill;
    logic wr_done;
    logic wr_upd;
    logic done;

    assign idx_core = INDEXWIDTH'(addr_index(core_addr, INDEXWIDTH));
    assign idx_lat  = INDEXWIDTH'(addr_index(addr_q, INDEXWIDTH));
    assign tag_lat  = TAGWIDTH'(addr_tag(addr_q, INDEXWIDTH));
    assign hit      = valid_q && (tag_q == tag_lat);

`ifdef CACHE_FLUSH_EN
    logic flush_pend;
    assign flush_go = flush_req || flush_pend;
`else
    assign flush_go = 1'b0;
`endif

    // rst gates every side effect so a reset cycle never writes the arrays
    assign accept  = !rst && state == IDLE && core_req && !flush_go;
    assign rd_hit  = !rst && state == LOOKUP && !we_q && hit;
    assign fill    = !rst && state == READ_MISS && mem.mem_ack;
    assign wr_done = !rst && state == WRITE_MEM && mem.mem_ack;
    assign wr_upd  = wr_done && hit_q;
    assign done    = rd_hit || fill || wr_done;

    assign core_stall = core_req && !done;
    assign arr_oe     = accept || (!rst && state == LOOKUP);

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = word_addr(addr_q);
    assign mem.mem_wdata = wdata_q;

    always_comb begin
        arr_cs     = 1'b0;
        arr_web    = 1'b1;
        arr_index  = idx_lat;
        valid_din  = 1'b0;
        tag_din    = '0;
        data_din   = '0;
        core_rdata = '0;
        unique case (1'b1)
            accept: begin
                arr_cs    = 1'b1;
                arr_index = idx_core;
            end
            rd_hit: begin
                core_rdata = data_q;
            end
            fill: begin
                arr_cs     = 1'b1;
                arr_web    = 1'b0;
                valid_din  = 1'b1;
                tag_din    = tag_lat;
                data_din   = mem.mem_rdata;
                core_rdata = mem.mem_rdata;
            end
            wr_upd: begin
                arr_cs    = 1'b1;
                arr_web   = 1'b0;
                valid_din = 1'b1;
                tag_din   = tag_lat;
                data_din  = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            hit_q     <= 1'b0;
            mem_req_q <= 1'b0;
`ifdef CACHE_FLUSH_EN
            flush_pend  <= 1'b0;
            valid_flush <= 1'b0;
`endif
        end else begin
`ifdef CACHE_FLUSH_EN
            if (flush_req && state != IDLE && state != FLUSH)
                flush_pend <= 1'b1;
`endif
            unique case (state)
                IDLE: begin
                    if (flush_go) begin
`ifdef CACHE_FLUSH_EN
                        state       <= FLUSH;
                        valid_flush <= 1'b1;
                        flush_pend  <= 1'b0;
`endif
                    end else if (core_req) begin
                        state   <= LOOKUP;
                        addr_q  <= core_addr;
                        we_q    <= core_we;
                        wdata_q <= core_wdata;
                    end
                end
                LOOKUP: begin
                    hit_q <= hit;
                    if (we_q) begin
                        state     <= WRITE_MEM;
                        mem_req_q <= 1'b1;
                    end else if (hit) begin
                        state <= IDLE;
                    end else begin
                        state     <= READ_MISS;
                        mem_req_q <= 1'b1;
                    end
                end
                READ_MISS, WRITE_MEM: begin
                    if (mem.mem_ack) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
`ifdef CACHE_FLUSH_EN
                FLUSH: begin
                    state       <= IDLE;
                    valid_flush <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl with SRAM, memory and cache reference models.
// Define CACHE_FLUSH_EN to also exercise the flush handshake.
module tb_dcache_ctrl;

    localparam int IW = 6;
    localparam int TW = 30 - IW;
    localparam int NL = 1 << IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we;
    logic [31:0]   core_addr, core_wdata, core_rdata;
    logic          core_stall;
    logic [IW-1:0] arr_index;
    logic          arr_cs, arr_oe, arr_web;
    logic          valid_q, valid_din;
    logic [TW-1:0] tag_q, tag_din;
    logic [31:0]   data_q, data_din;
`ifdef CACHE_FLUSH_EN
    logic          flush_req, valid_flush;
`endif

    dcache_ctrl_if mif ();

    dcache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .arr_index  (arr_index),
        .arr_cs     (arr_cs),
        .arr_oe     (arr_oe),
        .arr_web    (arr_web),
        .valid_q    (valid_q),
        .valid_din  (valid_din),
        .tag_q      (tag_q),
        .tag_din    (tag_din),
        .data_q     (data_q),
        .data_din   (data_din),
`ifdef CACHE_FLUSH_EN
        .flush_req  (flush_req),
        .valid_flush(valid_flush),
`endif
        .mem        (mif)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM arrays standing outside the controller
    logic          sv [NL];
    logic [TW-1:0] st [NL];
    logic [31:0]   sd [NL];
    int            nwr = 0;

    initial begin
        for (int i = 0; i < NL; i++) begin
            sv[i] = 1'b0;
            st[i] = '0;
            sd[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (arr_cs && !arr_web) begin
            sv[arr_index] <= valid_din;
            st[arr_index] <= tag_din;
            sd[arr_index] <= data_din;
            nwr <= nwr + 1;
        end else if (arr_cs) begin
            valid_q <= sv[arr_index];
            tag_q   <= st[arr_index];
            data_q  <= sd[arr_index];
        end
`ifdef CACHE_FLUSH_EN
        if (valid_flush)
            for (int i = 0; i < NL; i++) sv[i] <= 1'b0;
`endif
    end

    // Reference: backing memory plus the expected cache contents
    logic [31:0]   ref_mem [logic [29:0]];
    logic          rv [NL];
    logic [TW-1:0] rt [NL];
    logic [31:0]   rd [NL];

    int ncmp = 0;
    int nbad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int dly_in,
                          input logic fl);
        int            ix, dly, ncyc, wcnt, ack_cyc, exp_cyc;
        logic [TW-1:0] tg;
        logic [29:0]   wa;
        logic          exp_hit, exp_used, used, acked, done;
        logic [31:0]   exp_rd;
        ix = int'((addr >> 2) % NL);
        tg = TW'(addr >> (IW + 2));
        wa = addr[31:2];
        if (!ref_mem.exists(wa)) ref_mem[wa] = $urandom;
`ifdef CACHE_FLUSH_EN
        if (fl) for (int i = 0; i < NL; i++) rv[i] = 1'b0;
`endif
        exp_hit  = rv[ix] && rt[ix] == tg;
        exp_used = we || !exp_hit;
        exp_rd   = ref_mem[wa];
        dly = dly_in < 0 ? int'($urandom_range(0, 3)) : dly_in;
        exp_cyc = (fl ? 2 : 0) + (exp_used ? 3 + dly : 2);
        @(negedge clk);
        core_req = 1'b1; core_we = we;
        core_addr = addr; core_wdata = wd;
`ifdef CACHE_FLUSH_EN
        flush_req = fl;
        begin : fmon
            int fcnt;
            fcnt = 0;
`endif
        ncyc = 0; wcnt = 0; ack_cyc = 0;
        used = 1'b0; acked = 1'b0; done = 1'b0;
        while (!done && ncyc < 40) begin
            ncyc++;
            #1;
`ifdef CACHE_FLUSH_EN
            if (valid_flush) fcnt++;
`endif
            if (mif.mem_req) begin
                chk("mem_addr", mif.mem_addr, {addr[31:2], 2'b00});
                if (!used) begin
                    chk("mem_we", mif.mem_we, we);
                    if (we) chk("mem_wdata", mif.mem_wdata, wd);
                end
                used = 1'b1;
                if (wcnt == dly) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = we ? $urandom : exp_rd;
                    acked = 1'b1; ack_cyc = ncyc;
                    #1;
                end
                wcnt++;
            end
            if (!core_stall) done = 1'b1;
            else begin
                @(negedge clk);
                mif.mem_ack = 1'b0;
`ifdef CACHE_FLUSH_EN
                flush_req = 1'b0;
`endif
            end
        end
        chk("timeout", done, 1'b1);
        chk("mem_used", used, exp_used);
        chk("latency", ncyc, exp_cyc);
        if (!we) chk("rdata", core_rdata, exp_rd);
        if (exp_used) chk("done_at_ack", ncyc, ack_cyc);
        @(posedge clk);
        if (we) begin
            ref_mem[wa] = wd;
            if (exp_hit) rd[ix] = wd;
        end else if (!exp_hit) begin
            rv[ix] = 1'b1; rt[ix] = tg; rd[ix] = exp_rd;
        end
        @(negedge clk);
        core_req = 1'b0;
        mif.mem_ack = 1'b0;
        #1;
        chk("req_drop", mif.mem_req, 1'b0);
        chk("arr_valid", sv[ix], rv[ix]);
        if (rv[ix]) begin
            chk("arr_tag", st[ix], rt[ix]);
            chk("arr_data", sd[ix], rd[ix]);
        end
`ifdef CACHE_FLUSH_EN
        if (fl) chk("flush_pulse", fcnt, 1);
        end
`endif
    endtask

    task automatic reset_mid();
        int          n, wr0;
        logic [31:0] addr;
        addr = 32'h2000_0044;
        if (!ref_mem.exists(addr[31:2])) ref_mem[addr[31:2]] = $urandom;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = addr;
        n = 0;
        #1;
        while (!mif.mem_req && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("rst_in_miss", mif.mem_req, 1'b1);
        wr0 = nwr;
        rst = 1'b1; core_req = 1'b0;
        @(negedge clk); #1;
        chk("rst_memreq", mif.mem_req, 1'b0);
        chk("rst_rdata", core_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_nowrite", nwr, wr0);
        chk("rst_valid", sv[17], rv[17]);
    endtask

    initial begin
        logic [31:0] a;
        logic        w, f;
        for (int i = 0; i < NL; i++) begin
            rv[i] = 1'b0; rt[i] = '0; rd[i] = '0;
        end
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0;
        core_addr = '0; core_wdata = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
`ifdef CACHE_FLUSH_EN
        flush_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", mif.mem_req, 1'b0);
        chk("rst_arr_cs", arr_cs, 1'b0);
        chk("rst_arr_web", arr_web, 1'b1);
        chk("rst_core_rdata", core_rdata, 32'h0);
        rst = 1'b0;

        ref_mem[30'h10] = 32'hDEAD_BEEF;
        access(1'b0, 32'h0000_0040, 32'h0, 3, 1'b0);
        access(1'b0, 32'h0000_0040, 32'h0, -1, 1'b0);
        access(1'b1, 32'h0000_0040, 32'h1234_5678, -1, 1'b0);
        access(1'b0, 32'h0000_0040, 32'h0, -1, 1'b0);
        access(1'b1, 32'h0000_0080, 32'hCAFE_F00D, -1, 1'b0);
        access(1'b0, 32'h1000_0040, 32'h0, -1, 1'b0);
        access(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0);
        reset_mid();
        access(1'b0, 32'h2000_0044, 32'h0, -1, 1'b0);

        @(negedge clk);
        mif.mem_ack = 1'b1;
        #1;
        chk("stray_ack_cs", arr_cs, 1'b0);
        @(negedge clk);
        mif.mem_ack = 1'b0;
        #1;
        chk("stray_ack_req", mif.mem_req, 1'b0);
        access(1'b0, 32'h0000_0040, 32'h0, -1, 1'b0);

`ifdef CACHE_FLUSH_EN
        access(1'b0, 32'h0000_0040, 32'h0, -1, 1'b1);
`endif
        for (int k = 0; k < 80; k++) begin
            a = ($urandom_range(0, 2) << 28) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            w = $urandom_range(0, 2) == 0;
            f = 1'b0;
`ifdef CACHE_FLUSH_EN
            f = $urandom_range(0, 9) == 0;
`endif
            access(w, a, $urandom, -1, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
